// File: rtl/pixel_frame_streamer_if.sv
// Frame-buffer read port and valid/ready pixel stream of pixel_frame_streamer.
// The master modport is the streamer side; slave is the buffer/downstream side.
interface pixel_frame_streamer_if #(
    parameter int W  = 8,
    parameter int AW = 17
);
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          y_valid;
    logic          y_ready;
    logic [W-1:0]  y_data;
    logic          y_last;

    modport master (
        output rd_en, rd_addr, y_valid, y_data, y_last,
        input  rd_data, y_ready
    );

    modport slave (
        input  rd_en, rd_addr, y_valid, y_data, y_last,
        output rd_data, y_ready
    );
endinterface

// File: rtl/pixel_frame_streamer.sv
// Raster-order frame reader: streams IMG_WIDTH x IMG_HEIGHT pixels from a
// synchronous-read frame buffer through a 2-entry FIFO that hides read latency.
module pixel_frame_streamer #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int W          = 8,
    parameter int AW         = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    pixel_frame_streamer_if.master bus
);
    localparam int N = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [AW-1:0] rd_addr_r;
    logic [AW-1:0] pix_cnt_r;
    logic          inflight_r;
    logic          frame_done_r;
    logic [1:0]    fifo_count_r;
    logic [W-1:0]  head_r;
    logic [W-1:0]  tail_r;
    logic          pop_s;
    logic          rd_en_s;
    logic          done_set_s;
    logic          start_ok_s;
    logic          credit_ok_s;
    logic [2:0]    occupancy_s;

    assign pop_s       = (fifo_count_r != 2'd0) & bus.y_ready;
    assign start_ok_s  = (state_r == ST_IDLE) & start;
    // Buffered plus in-flight reads after this cycle's pop must leave room for one more.
    assign occupancy_s = {1'b0, fifo_count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign credit_ok_s = (occupancy_s < 3'd2);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, read strobe and end-of-frame detection.
    always_comb begin
        state_next_s = state_r;
        rd_en_s      = 1'b0;
        done_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_STREAM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (credit_ok_s) begin
                    rd_en_s = 1'b1;
                    if (rd_addr_r == LAST_IDX) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_STREAM;
                    end
                end else begin
                    state_next_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (pop_s && (pix_cnt_r == LAST_IDX)) begin
                    state_next_s = ST_IDLE;
                    done_set_s   = 1'b1;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Read address, output pixel counter, in-flight flag and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_r    <= '0;
            pix_cnt_r    <= '0;
            inflight_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            inflight_r   <= rd_en_s;
            frame_done_r <= done_set_s;
            if (start_ok_s) begin
                rd_addr_r <= '0;
                pix_cnt_r <= '0;
            end else begin
                // Both counters saturate at the last index so they never wrap mid-frame.
                if (rd_en_s && (rd_addr_r != LAST_IDX)) begin
                    rd_addr_r <= rd_addr_r + AW'(1);
                end else begin
                    rd_addr_r <= rd_addr_r;
                end
                if (pop_s && (pix_cnt_r != LAST_IDX)) begin
                    pix_cnt_r <= pix_cnt_r + AW'(1);
                end else begin
                    pix_cnt_r <= pix_cnt_r;
                end
            end
        end
    end

    // Two-entry FIFO; head_r drives y_data directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_count_r <= 2'd0;
            head_r       <= '0;
            tail_r       <= '0;
        end else begin
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (fifo_count_r == 2'd0) begin
                        head_r <= bus.rd_data;
                    end else begin
                        tail_r <= bus.rd_data;
                    end
                    fifo_count_r <= fifo_count_r + 2'd1;
                end
                2'b01: begin
                    if (fifo_count_r == 2'd2) begin
                        head_r <= tail_r;
                    end else begin
                        head_r <= head_r;
                    end
                    fifo_count_r <= fifo_count_r - 2'd1;
                end
                2'b11: begin
                    if (fifo_count_r == 2'd1) begin
                        head_r <= bus.rd_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= bus.rd_data;
                    end
                end
                default: begin
                    fifo_count_r <= fifo_count_r;
                end
            endcase
        end
    end

    assign busy        = (state_r != ST_IDLE);
    assign frame_done  = frame_done_r;
    assign bus.rd_en   = rd_en_s;
    assign bus.rd_addr = rd_addr_r;
    assign bus.y_valid = (fifo_count_r != 2'd0);
    assign bus.y_data  = head_r;
    assign bus.y_last  = (pix_cnt_r == LAST_IDX) & (fifo_count_r != 2'd0);
endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Directed bench for pixel_frame_streamer on a 4x2 frame with mem[i] = i+10.
module tb_pixel_frame_streamer;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    pixel_frame_streamer_if #(.W(8), .AW(3)) bus ();

    pixel_frame_streamer #(
        .IMG_WIDTH (4),
        .IMG_HEIGHT(2),
        .W         (8),
        .AW        (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .frame_done(frame_done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Frame buffer model: one-cycle read latency, contents addr+10.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= 8'(bus.rd_addr) + 8'd10;
    end

    // Stream monitor: records handshakes/reads and counts protocol violations.
    logic [7:0] popped[$];
    bit         lastq[$];
    logic [2:0] addrq[$];
    int  outstanding = 0;
    int  credit_viol = 0;
    int  stable_viol = 0;
    int  last_viol   = 0;
    int  done_cnt    = 0;
    bit  stall_prev  = 1'b0;
    logic [7:0] data_prev = 8'd0;

    always @(negedge clk) begin
        bit pop;
        if (rst) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            pop = bus.y_valid && bus.y_ready;
            if (bus.rd_en && ((outstanding - int'(pop)) >= 2)) credit_viol++;
            if (stall_prev && (!bus.y_valid || (bus.y_data !== data_prev))) stable_viol++;
            if (bus.y_last && !bus.y_valid) last_viol++;
            if (pop) begin
                popped.push_back(bus.y_data);
                lastq.push_back(bus.y_last);
            end
            if (bus.rd_en) addrq.push_back(bus.rd_addr);
            if (frame_done) done_cnt++;
            outstanding = outstanding + int'(bus.rd_en) - int'(pop);
            stall_prev  = bus.y_valid && !bus.y_ready;
            data_prev   = bus.y_data;
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        bus.y_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, frame_done, bus.rd_en, bus.y_valid, bus.y_last} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {busy, frame_done, bus.rd_en, bus.y_valid, bus.y_last});
        end
        n_checks++;
        if (bus.rd_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_rd_addr: got %0d expected 0", bus.rd_addr);
        end
        n_checks++;
        if (bus.y_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_y_data: got %0d expected 0", bus.y_data);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.rd_en, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL idle_no_read c%0d: got rd_en,busy=%b expected 00", c, {bus.rd_en, busy});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_full_rate;
        logic exp_v;
        logic exp_rd;
        bus.y_ready = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            start = (c == 0);
            @(negedge clk);
            exp_v  = (c >= 3) && (c <= 10);
            exp_rd = (c >= 1) && (c <= 8);
            n_checks++;
            if (busy !== ((c >= 1) && (c <= 10))) begin
                n_fail++;
                $display("FAIL full_busy c%0d: got %b", c, busy);
            end
            n_checks++;
            if (frame_done !== (c == 11)) begin
                n_fail++;
                $display("FAIL full_frame_done c%0d: got %b expected %b", c, frame_done, c == 11);
            end
            n_checks++;
            if (bus.y_valid !== exp_v) begin
                n_fail++;
                $display("FAIL full_y_valid c%0d: got %b expected %b", c, bus.y_valid, exp_v);
            end
            n_checks++;
            if (bus.y_last !== (c == 10)) begin
                n_fail++;
                $display("FAIL full_y_last c%0d: got %b expected %b", c, bus.y_last, c == 10);
            end
            if (exp_v) begin
                n_checks++;
                if (bus.y_data !== 8'(c + 7)) begin
                    n_fail++;
                    $display("FAIL full_y_data c%0d: got %0d expected %0d", c, bus.y_data, c + 7);
                end
            end
            n_checks++;
            if (bus.rd_en !== exp_rd) begin
                n_fail++;
                $display("FAIL full_rd_en c%0d: got %b expected %b", c, bus.rd_en, exp_rd);
            end
            if (exp_rd) begin
                n_checks++;
                if (bus.rd_addr !== 3'(c - 1)) begin
                    n_fail++;
                    $display("FAIL full_rd_addr c%0d: got %0d expected %0d", c, bus.rd_addr, c - 1);
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_backpressure;
        int  pbase;
        int  dbase;
        int  cv;
        int  sv;
        int  lv;
        bit  done;
        pbase = popped.size();
        dbase = done_cnt;
        cv    = credit_viol;
        sv    = stable_viol;
        lv    = last_viol;
        done  = 1'b0;
        for (int c = 0; (c < 60) && !done; c++) begin
            start = (c == 0);
            bus.y_ready = (c % 2 == 0);
            @(negedge clk);
            if (frame_done) done = 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        bus.y_ready = 1'b1;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL bp_timeout: got no frame_done within 60 cycles, expected one");
        end
        n_checks++;
        if (popped.size() - pbase !== N) begin
            n_fail++;
            $display("FAIL bp_count: got %0d pixels expected %0d", popped.size() - pbase, N);
        end else begin
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (popped[pbase + i] !== 8'(i + 10)) begin
                    n_fail++;
                    $display("FAIL bp_pixel %0d: got %0d expected %0d", i, popped[pbase + i], i + 10);
                end
                n_checks++;
                if (lastq[pbase + i] !== (i == N - 1)) begin
                    n_fail++;
                    $display("FAIL bp_last %0d: got %b expected %b", i, lastq[pbase + i], i == N - 1);
                end
            end
        end
        n_checks++;
        if (credit_viol - cv !== 0) begin
            n_fail++;
            $display("FAIL bp_credit: got %0d reads beyond two outstanding, expected 0", credit_viol - cv);
        end
        n_checks++;
        if (stable_viol - sv !== 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d stalled-output changes, expected 0", stable_viol - sv);
        end
        n_checks++;
        if (last_viol - lv !== 0) begin
            n_fail++;
            $display("FAIL bp_last_qual: got %0d y_last without y_valid, expected 0", last_viol - lv);
        end
        n_checks++;
        if (done_cnt - dbase !== 1) begin
            n_fail++;
            $display("FAIL bp_done_count: got %0d expected 1", done_cnt - dbase);
        end
    endtask

    task automatic test_long_stall;
        int abase;
        int sv;
        abase = addrq.size();
        sv    = stable_viol;
        for (int c = 0; c <= 31; c++) begin
            start = (c == 0);
            bus.y_ready = (c >= 21);
            @(negedge clk);
            if (c == 20) begin
                n_checks++;
                if (addrq.size() - abase !== 2) begin
                    n_fail++;
                    $display("FAIL stall_reads: got %0d reads expected 2", addrq.size() - abase);
                end else begin
                    n_checks++;
                    if ({addrq[abase], addrq[abase + 1]} !== {3'd0, 3'd1}) begin
                        n_fail++;
                        $display("FAIL stall_addrs: got %0d,%0d expected 0,1", addrq[abase], addrq[abase + 1]);
                    end
                end
                n_checks++;
                if ({bus.y_valid, bus.y_data} !== {1'b1, 8'd10}) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%b data=%0d expected valid=1 data=10",
                             bus.y_valid, bus.y_data);
                end
            end
            if ((c >= 21) && (c <= 28)) begin
                n_checks++;
                if ({bus.y_valid, bus.y_data} !== {1'b1, 8'(c - 11)}) begin
                    n_fail++;
                    $display("FAIL stall_resume c%0d: got valid=%b data=%0d expected valid=1 data=%0d",
                             c, bus.y_valid, bus.y_data, c - 11);
                end
            end
            if (c == 29) begin
                n_checks++;
                if (frame_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_done: got %b expected 1", frame_done);
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        n_checks++;
        if (stable_viol - sv !== 0) begin
            n_fail++;
            $display("FAIL stall_stable: got %0d stalled-output changes, expected 0", stable_viol - sv);
        end
    endtask

    task automatic test_start_handling;
        int pbase;
        pbase = popped.size();
        bus.y_ready = 1'b1;
        for (int c = 0; c <= 24; c++) begin
            start = (c == 0) || (c == 5) || (c == 11);
            @(negedge clk);
            if ((c >= 1) && (c <= 8)) begin
                n_checks++;
                if ({bus.rd_en, bus.rd_addr} !== {1'b1, 3'(c - 1)}) begin
                    n_fail++;
                    $display("FAIL start_ignored c%0d: got rd_en=%b addr=%0d expected rd_en=1 addr=%0d",
                             c, bus.rd_en, bus.rd_addr, c - 1);
                end
            end
            if (c == 11) begin
                n_checks++;
                if ({frame_done, busy} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL start_done_cycle: got done,busy=%b expected 10", {frame_done, busy});
                end
            end
            if (c == 12) begin
                n_checks++;
                if ({bus.rd_en, bus.rd_addr, busy} !== {1'b1, 3'd0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL start_restart: got rd_en=%b addr=%0d busy=%b expected 1,0,1",
                             bus.rd_en, bus.rd_addr, busy);
                end
            end
            if (c == 22) begin
                n_checks++;
                if (frame_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL start_second_done: got %b expected 1", frame_done);
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        n_checks++;
        if (popped.size() - pbase !== 2 * N) begin
            n_fail++;
            $display("FAIL start_count: got %0d pixels expected %0d", popped.size() - pbase, 2 * N);
        end else begin
            for (int i = 0; i < 2 * N; i++) begin
                n_checks++;
                if (popped[pbase + i] !== 8'((i % N) + 10)) begin
                    n_fail++;
                    $display("FAIL start_pixel %0d: got %0d expected %0d", i, popped[pbase + i], (i % N) + 10);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int pbase;
        int dbase;
        int p2;
        pbase = popped.size();
        dbase = done_cnt;
        p2    = 0;
        bus.y_ready = 1'b1;
        for (int c = 0; c <= 34; c++) begin
            start = (c == 0) || (c == 21);
            rst   = (c == 6) || (c == 7);
            if (c == 21) p2 = popped.size();
            @(negedge clk);
            if (c == 6) begin
                n_checks++;
                if ({busy, frame_done, bus.rd_en, bus.rd_addr, bus.y_valid, bus.y_data, bus.y_last} !== 16'd0) begin
                    n_fail++;
                    $display("FAIL midrst_outputs: got busy=%b done=%b rd_en=%b addr=%0d valid=%b data=%0d last=%b expected all 0",
                             busy, frame_done, bus.rd_en, bus.rd_addr, bus.y_valid, bus.y_data, bus.y_last);
                end
            end
            if (c == 20) begin
                n_checks++;
                if (done_cnt - dbase !== 0) begin
                    n_fail++;
                    $display("FAIL midrst_no_done: got %0d frame_done pulses expected 0", done_cnt - dbase);
                end
                n_checks++;
                if (popped.size() - pbase !== 3) begin
                    n_fail++;
                    $display("FAIL midrst_pre_count: got %0d pixels before reset expected 3", popped.size() - pbase);
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst   = 1'b0;
        n_checks++;
        if (popped.size() - p2 !== N) begin
            n_fail++;
            $display("FAIL midrst_restart_count: got %0d pixels expected %0d", popped.size() - p2, N);
        end else begin
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (popped[p2 + i] !== 8'(i + 10)) begin
                    n_fail++;
                    $display("FAIL midrst_pixel %0d: got %0d expected %0d", i, popped[p2 + i], i + 10);
                end
            end
        end
        n_checks++;
        if (done_cnt - dbase !== 1) begin
            n_fail++;
            $display("FAIL midrst_done_count: got %0d expected 1", done_cnt - dbase);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.y_ready = 1'b0;
        test_reset();
        test_full_rate();
        test_backpressure();
        repeat (2) @(posedge clk);
        #1;
        test_long_stall();
        test_start_handling();
        repeat (2) @(posedge clk);
        #1;
        test_reset_mid();
        n_checks++;
        if (credit_viol !== 0) begin
            n_fail++;
            $display("FAIL global_credit: got %0d reads beyond two outstanding, expected 0", credit_viol);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
